irq_encoder_8b: RTL and testbench
=================================

# irq_encoder_8b

Sequential 8-to-3 priority encoder for the 8-bit CPU control path; the encoding counterpart of the 3-bit active-low line decoder. Captures falling edges on eight active-low request lines into a sticky pending register, presents the highest-priority pending index with a valid/ack handshake, and clears that bit on acknowledge. Provides 74LS148-style cascade outputs (`gs_n`, `eo_n`) for chaining two encoders.

## Interface
- No parameters; width fixed at 8 requests / 3-bit code.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ei_n` in 1: active-low enable input (cascade in).
- `req_n` in 8: active-low request lines; bit i = source i; synchronous to `clk`.
- `ack` in 1: consumer accepts current `code`; honoured only while `valid`=1.
- `code` out 3: active-high index of the granted request.
- `valid` out 1: `code` holds a granted, unacknowledged request.
- `pending` out 8: sticky pending bits, active-high.
- `gs_n` out 1: active-low group select; 0 when `ei_n`=0 and any `pending` bit set.
- `eo_n` out 1: active-low enable out; 0 when `ei_n`=0 and `pending`==0.

## Operation
- Edge capture: register `req_prev` (reset 8'hFF); assertion event for bit i = `req_prev[i]` & ~`req_n[i]`. Events are captured only while `ei_n`=0; events while `ei_n`=1 are discarded.
- `pending[i]` set on event i; cleared on accepted ack with `code`==i. If set and clear coincide on the same bit, set wins (event not lost).
- Held-low request produces exactly one event; it must go high and low again to re-request.
- FSM, 2 states:
  - IDLE: `valid`=0. If `ei_n`=0 and `pending`!=0: load `code` with selected index, go GRANT.
  - GRANT: `valid`=1, `code` stable. On `ack`=1: clear `pending[code]`, go IDLE. `ei_n` going high does not revoke a grant.
- Fixed priority: index 7 highest, 0 lowest.
- Selection uses registered `pending` only (not same-cycle events).
- `gs_n`, `eo_n`: combinational from `ei_n` and registered `pending`. `gs_n` and `eo_n` are never both 0.
- Reset (async, any state, mid-grant): `pending`=0, `req_prev`=8'hFF, `code`=0, `valid`=0, state IDLE, `gs_n`=1, `eo_n`=`ei_n`. First cycle after reset release, a low `req_n` bit counts as an event.

## Timing
- `req_n[i]` low before edge N → `pending[i]`=1 after edge N → `valid`=1, `code`=i after edge N+1 (2-cycle latency).
- `ack` sampled at edge M with `valid`=1 → `valid`=0 after M; next grant (if pending remains) `valid`=1 after M+1. Minimum one IDLE cycle between grants; max throughput one grant per 2 cycles.
- `ack` while `valid`=0: ignored, no state change.
- `code` changes only on IDLE→GRANT.
- `gs_n`/`eo_n` follow `ei_n` combinationally, `pending` with 1-cycle latency from event.

## Configuration
- `IRQ_ROUND_ROBIN_EN` defined: rotating priority. 3-bit pointer `ptr` (reset 7); search order `ptr`, `ptr`-1, …, wrapping 0→7. On accepted ack of index k, `ptr` <= k-1 mod 8 (k=0 → 7). Reset restores `ptr`=7.
- Not defined: fixed priority 7 > … > 0; no pointer logic.
- Ports, latency and handshake identical in both builds.

## Test plan
- Reset, `ei_n`=0, drive `req_n`=8'b1111_1011 → `pending`=8'h04 after 1 edge, `valid`=1, `code`=2, `gs_n`=0, `eo_n`=1 after 2 edges; `ack` → `pending`=0, `valid`=0, `eo_n`=0.
- Same-cycle events on bits 1, 5, 6 → grants in order 6, 5, 1 (fixed build) with one IDLE cycle between; `req_n` held low throughout produces no re-grant.
- During GRANT of `code`=3, new event on bit 3 in the same cycle as `ack` → `pending[3]` stays 1, next grant `code`=3.
- `ei_n`=1: event on bit 4 → `pending` unchanged, `gs_n`=1, `eo_n`=1; with `pending`=8'h10 and `ei_n` raised in GRANT → `valid` held until `ack`.
- Assert `rst_n`=0 mid-GRANT → immediately `valid`=0, `code`=0, `pending`=0, `gs_n`=1, with no clock edge.
- `IRQ_ROUND_ROBIN_EN`: keep bits 7 and 2 re-requested after each ack → grants alternate 7, 2, 7, 2 instead of 7, 7, 7.

Source files
------------

// File: rtl/irq_encoder_8b_if.sv
// irq_encoder_8b_if: request/grant bus between the 8-to-3 interrupt encoder (slave) and its consumer (master)
interface irq_encoder_8b_if;
  logic       ei_n;
  logic [7:0] req_n;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       gs_n;
  logic       eo_n;
  modport master(output ei_n, req_n, ack, input code, valid, pending, gs_n, eo_n);
  modport slave(input ei_n, req_n, ack, output code, valid, pending, gs_n, eo_n);
endinterface

// File: rtl/irq_encoder_8b.sv
// irq_encoder_8b: sequential 8-to-3 priority interrupt encoder with valid/ack grant and 74LS148-style cascade
//   clk, rst_n (async, active-low); bus.slave: ei_n, req_n[7:0], ack in; code[2:0], valid, pending[7:0], gs_n, eo_n out
//   IRQ_ROUND_ROBIN_EN defined: rotating priority via pointer; undefined: fixed priority 7 > ... > 0
module irq_encoder_8b (
  input logic clk,
  input logic rst_n,
  irq_encoder_8b_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_req_prev, r_pending;
  logic [2:0] r_code, w_sel, w_ptr;
  logic [7:0] w_event, w_clr;
  logic       w_accept, w_load;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= 3'd7;
    else if (w_accept) r_ptr <= r_code - 3'd1;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 3'd7;
`endif
  assign w_event  = r_req_prev & ~bus.req_n & {8{~bus.ei_n}};
  assign w_accept = (r_state == GRANT) && bus.ack;
  assign w_clr    = w_accept ? (8'd1 << r_code) : 8'd0;
  // Search from w_ptr downward with wrap; the last hit (k=0, the pointer itself) has highest priority.
  always_comb begin
    w_sel = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (r_pending[3'(w_ptr - 3'(k))]) w_sel = 3'(w_ptr - 3'(k));
  end
  always_comb begin
    w_state_nxt = r_state;
    w_load = 1'b0;
    if (r_state == IDLE) begin
      w_load = !bus.ei_n && (|r_pending);
      w_state_nxt = w_load ? GRANT : IDLE;
    end else
      w_state_nxt = bus.ack ? IDLE : GRANT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_req_prev <= 8'hFF;
      r_pending <= 8'h00;
      r_code <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_req_prev <= bus.req_n;
      r_pending <= (r_pending & ~w_clr) | w_event;
      if (w_load) r_code <= w_sel;
    end
  assign bus.code    = r_code;
  assign bus.valid   = r_state == GRANT;
  assign bus.pending = r_pending;
  assign bus.gs_n    = bus.ei_n | ~(|r_pending);
  assign bus.eo_n    = bus.ei_n | (|r_pending);
endmodule

// File: tb/tb_irq_encoder_8b.sv
// tb_irq_encoder_8b: directed self-checking bench for irq_encoder_8b
module tb_irq_encoder_8b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  irq_encoder_8b_if bus();
  irq_encoder_8b dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  logic [2:0] exp_rr [4];
  initial begin
`ifdef IRQ_ROUND_ROBIN_EN
    exp_rr = '{3'd7, 3'd2, 3'd7, 3'd2};
`else
    exp_rr = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    bus.ei_n = 1'b0; bus.req_n = 8'hFF; bus.ack = 1'b0;
    #2;
    check("rst_valid", bus.valid, 0);
    check("rst_code", bus.code, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_gs_n", bus.gs_n, 1);
    check("rst_eo_n", bus.eo_n, 0);
    step(1); rst_n = 1'b1;
    // single request on bit 2
    bus.req_n = 8'hFB; step(1);
    check("t1_pending", bus.pending, 8'h04);
    check("t1_valid0", bus.valid, 0);
    step(1);
    check("t1_valid", bus.valid, 1);
    check("t1_code", bus.code, 2);
    check("t1_gs_n", bus.gs_n, 0);
    check("t1_eo_n", bus.eo_n, 1);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t1_pend_clr", bus.pending, 0);
    check("t1_valid_clr", bus.valid, 0);
    check("t1_eo_n_clr", bus.eo_n, 0);
    bus.req_n = 8'hFF; step(1);
    // simultaneous events on 1, 5, 6, held low
    bus.req_n = 8'b1001_1101; step(1);
    check("t2_pending", bus.pending, 8'h62);
    step(1);
    check("t2_v6", bus.valid, 1); check("t2_c6", bus.code, 6);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t2_idle1", bus.valid, 0); check("t2_pend1", bus.pending, 8'h22);
    step(1);
    check("t2_v5", bus.valid, 1); check("t2_c5", bus.code, 5);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t2_idle2", bus.valid, 0); check("t2_pend2", bus.pending, 8'h02);
    step(1);
    check("t2_v1", bus.valid, 1); check("t2_c1", bus.code, 1);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    step(3);
    check("t2_no_regrant", bus.valid, 0); check("t2_pend_end", bus.pending, 0);
    bus.req_n = 8'hFF; step(1);
    // new event on bit 3 coinciding with ack of code 3
    bus.req_n = 8'hF7; step(1);
    bus.req_n = 8'hFF; step(1);
    check("t3_code", bus.code, 3);
    bus.req_n = 8'hF7; bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t3_valid0", bus.valid, 0);
    check("t3_pend_kept", bus.pending, 8'h08);
    step(1);
    check("t3_regrant_v", bus.valid, 1); check("t3_regrant_c", bus.code, 3);
    bus.ack = 1'b1; bus.req_n = 8'hFF; step(1); bus.ack = 1'b0;
    check("t3_clr", bus.pending, 0);
    // ei_n high discards events
    bus.ei_n = 1'b1; bus.req_n = 8'hEF; step(1);
    check("t4_pend_dis", bus.pending, 0);
    check("t4_gs_n", bus.gs_n, 1); check("t4_eo_n", bus.eo_n, 1);
    bus.ei_n = 1'b0; bus.req_n = 8'hFF; step(1);
    bus.req_n = 8'hEF; step(1);
    check("t4_pend", bus.pending, 8'h10);
    step(1);
    check("t4_v", bus.valid, 1); check("t4_c", bus.code, 4);
    bus.ei_n = 1'b1; #1;
    check("t4_gs_n_hi", bus.gs_n, 1); check("t4_eo_n_hi", bus.eo_n, 1);
    step(2);
    check("t4_hold_v", bus.valid, 1); check("t4_hold_c", bus.code, 4);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t4_rel_v", bus.valid, 0); check("t4_rel_p", bus.pending, 0);
    bus.ei_n = 1'b0; bus.req_n = 8'hFF;
    // stray ack while idle
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    check("t5_ack_idle_v", bus.valid, 0); check("t5_ack_idle_p", bus.pending, 0);
    // async reset mid-grant
    bus.req_n = 8'hDF; step(2);
    check("t6_v", bus.valid, 1); check("t6_c", bus.code, 5);
    #2 rst_n = 1'b0; #1;
    check("t6_rst_v", bus.valid, 0); check("t6_rst_c", bus.code, 0);
    check("t6_rst_p", bus.pending, 0); check("t6_rst_gs", bus.gs_n, 1);
    step(1); rst_n = 1'b1; step(1);
    check("t6_first_evt", bus.pending, 8'h20);
    // priority rotation with bits 7 and 2 re-requested every ack
    rst_n = 1'b0; bus.req_n = 8'hFF; step(1); rst_n = 1'b1;
    bus.req_n = 8'h7B; step(1);
    check("t7_pend", bus.pending, 8'h84);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t7_v%0d", i), bus.valid, 1);
      check($sformatf("t7_c%0d", i), bus.code, exp_rr[i]);
      bus.req_n = 8'hFF; step(1);
      bus.req_n = 8'h7B; bus.ack = 1'b1; step(1);
      bus.ack = 1'b0; step(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
